// File: rtl/tm1637_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit TM1637 display among four sources, frame-aligned.
// Optional build macro TM1637_ARB_PRIORITY_EN makes source 0 pre-emptive.
module tm1637_display_arbiter #(
  parameter int unsigned DWELL_FRAMES = 4,
  parameter logic [15:0] IDLE_DATA    = 16'h0000
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        frame_done,
  input  logic [3:0]  src_valid,
  input  logic [63:0] src_data,
  output logic [3:0]  src_ack,
  output logic [15:0] disp_data,
  output logic [1:0]  active_src,
  output logic        active
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_FRAMES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state, state_nx;
  logic [15:0]   disp_nx;
  logic [1:0]    src_nx, last_src, last_nx, pick;
  logic [3:0]    ack_nx;
  logic [CW-1:0] dwell_cnt, dwell_nx;
  logic          active_nx, take, prio_hit;

  // First valid index after p, wrapping so p itself is visited last.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] p);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = p;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (valid[idx]) sel = idx;
    end
    return sel;
  endfunction

`ifdef TM1637_ARB_PRIORITY_EN
  assign prio_hit = src_valid[0];
`else
  assign prio_hit = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    disp_nx   = disp_data;
    src_nx    = active_src;
    last_nx   = last_src;
    dwell_nx  = dwell_cnt;
    ack_nx    = '0;
    active_nx = active;
    take      = 1'b0;
    pick      = rr_pick(src_valid, (state == IDLE) ? last_src : active_src);
    if (prio_hit) pick = 2'd0;

    if (frame_done) begin
      if (prio_hit) begin
        take = 1'b1;
      end else begin
        case (state)
          IDLE: if (|src_valid) take = 1'b1;
          SHOW: begin
            if (src_valid[active_src] && (dwell_cnt < DWELL_LAST)) begin
              // Live refresh of the current source within its dwell window
              disp_nx  = src_data[{active_src, 4'b0000} +: 16];
              ack_nx   = 4'b0001 << active_src;
              dwell_nx = dwell_cnt + 16'd1;
            end else if (|src_valid) begin
              take = 1'b1;
            end else begin
              state_nx  = IDLE;
              active_nx = 1'b0;
              disp_nx   = IDLE_DATA;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end

    if (take) begin
      state_nx  = SHOW;
      active_nx = 1'b1;
      src_nx    = pick;
      last_nx   = pick;
      disp_nx   = src_data[{pick, 4'b0000} +: 16];
      ack_nx    = 4'b0001 << pick;
      dwell_nx  = '0;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state      <= IDLE;
      disp_data  <= IDLE_DATA;
      active_src <= 2'd0;
      last_src   <= 2'd3;
      dwell_cnt  <= '0;
      src_ack    <= '0;
      active     <= 1'b0;
    end else begin
      state      <= state_nx;
      disp_data  <= disp_nx;
      active_src <= src_nx;
      last_src   <= last_nx;
      dwell_cnt  <= dwell_nx;
      src_ack    <= ack_nx;
      active     <= active_nx;
    end
  end

endmodule

// File: tb/tb_tm1637_display_arbiter.sv
// Bench for tm1637_display_arbiter: two instances (dwell 2 and dwell 1) against a behavioural model.
module tb_tm1637_display_arbiter;

  localparam int unsigned D0 = 2;
  localparam int unsigned D1 = 1;
  localparam logic [15:0] IDL0 = 16'h0000;
  localparam logic [15:0] IDL1 = 16'hD00D;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        frame_done = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [63:0] src_data = '0;

  logic [3:0]  dut_ack  [2];
  logic [15:0] dut_disp [2];
  logic [1:0]  dut_src  [2];
  logic        dut_act  [2];

  tm1637_display_arbiter #(.DWELL_FRAMES(D0), .IDLE_DATA(IDL0)) u_dut0 (
    .clk25(clk25), .rst(rst), .frame_done(frame_done), .src_valid(src_valid),
    .src_data(src_data), .src_ack(dut_ack[0]), .disp_data(dut_disp[0]),
    .active_src(dut_src[0]), .active(dut_act[0]));

  tm1637_display_arbiter #(.DWELL_FRAMES(D1), .IDLE_DATA(IDL1)) u_dut1 (
    .clk25(clk25), .rst(rst), .frame_done(frame_done), .src_valid(src_valid),
    .src_data(src_data), .src_ack(dut_ack[1]), .disp_data(dut_disp[1]),
    .active_src(dut_src[1]), .active(dut_act[1]));

  always #20 clk25 = ~clk25;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: what each display shows, expressed as "who is on screen and for how long".
  bit          m_show  [2];
  int          m_cur   [2];
  int          m_last  [2];
  int          m_dwell [2];
  logic [15:0] m_disp  [2];
  logic [3:0]  m_ack   [2];
  int          dwell_of [2] = '{D0, D1};
  logic [15:0] idle_of  [2] = '{IDL0, IDL1};

  function automatic int next_valid(input logic [3:0] v, input int p);
    for (int k = 1; k <= 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset(input int i);
    m_show[i] = 0; m_cur[i] = 0; m_last[i] = 3; m_dwell[i] = 0;
    m_disp[i] = idle_of[i]; m_ack[i] = '0;
  endtask

  task automatic show_src(input int i, input int n);
    m_show[i] = 1; m_cur[i] = n; m_last[i] = n; m_dwell[i] = 0;
    m_disp[i] = src_data[16*n +: 16];
    m_ack[i]  = 4'(1 << n);
  endtask

  task automatic model_step(input int i);
    int n;
    m_ack[i] = '0;
    if (rst) begin
      model_reset(i);
    end else if (frame_done) begin
`ifdef TM1637_ARB_PRIORITY_EN
      if (src_valid[0]) begin
        show_src(i, 0);
        return;
      end
`endif
      if (!m_show[i]) begin
        n = next_valid(src_valid, m_last[i]);
        if (n >= 0) show_src(i, n);
      end else if (src_valid[m_cur[i]] && (m_dwell[i] + 1 < dwell_of[i])) begin
        m_disp[i] = src_data[16*m_cur[i] +: 16];
        m_ack[i]  = 4'(1 << m_cur[i]);
        m_dwell[i]++;
      end else begin
        n = next_valid(src_valid, m_cur[i]);
        if (n >= 0) show_src(i, n);
        else begin
          m_show[i] = 0;
          m_disp[i] = idle_of[i];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("disp%0d", i), 32'(dut_disp[i]), 32'(m_disp[i]));
      check($sformatf("active%0d", i), 32'(dut_act[i]), 32'(m_show[i]));
      check($sformatf("ack%0d", i), 32'(dut_ack[i]), 32'(m_ack[i]));
      if (m_show[i]) check($sformatf("src%0d", i), 32'(dut_src[i]), 32'(m_cur[i]));
    end
  endtask

  task automatic tick(input logic r, input logic fd, input logic [3:0] v, input logic [63:0] d);
    @(negedge clk25);
    rst = r; frame_done = fd; src_valid = v; src_data = d;
    @(posedge clk25);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  logic [15:0] seq_exp [6];
  logic [3:0]  seq_ack [6];
  logic [3:0]  v_r;

  initial begin
    model_reset(0);
    model_reset(1);

    // Reset values
    tick(1'b1, 1'b0, 4'h0, 64'h0);
    tick(1'b1, 1'b1, 4'hF, 64'h0);
    check("rst_disp0", 32'(dut_disp[0]), 32'h0000);
    check("rst_disp1", 32'(dut_disp[1]), 32'hD00D);
    check("rst_active", 32'(dut_act[0]), 32'h0);
    check("rst_ack", 32'(dut_ack[0]), 32'h0);

    // No source valid: stays idle
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 4'h0, 64'h0);
      check("idle_disp", 32'(dut_disp[0]), 32'h0000);
      check("idle_ack", 32'(dut_ack[0]), 32'h0);
    end

    // Sources 0 and 2 alternate every two frames on the dwell-2 instance
`ifdef TM1637_ARB_PRIORITY_EN
    seq_exp = '{16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111};
    seq_ack = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`else
    seq_exp = '{16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h1111, 16'h1111};
    seq_ack = '{4'h1, 4'h1, 4'h4, 4'h4, 4'h1, 4'h1};
`endif
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b1, 4'b0101, 64'h0000_2222_0000_1111);
      check("seq_disp", 32'(dut_disp[0]), 32'(seq_exp[k]));
      check("seq_ack", 32'(dut_ack[0]), 32'(seq_ack[k]));
      tick(1'b0, 1'b0, 4'b0101, 64'h0000_2222_0000_1111);
      check("seq_ack_drop", 32'(dut_ack[0]), 32'h0);
    end

    // Dwell-1 instance: live value change, then everything drops
    tick(1'b1, 1'b0, 4'h0, 64'h0);
    tick(1'b0, 1'b1, 4'b0100, 64'h0000_ABCD_0000_0000);
    check("d1_first", 32'(dut_disp[1]), 32'hABCD);
    tick(1'b0, 1'b1, 4'b0100, 64'h0000_1234_0000_0000);
    check("d1_live", 32'(dut_disp[1]), 32'h1234);
    check("d1_ack", 32'(dut_ack[1]), 32'h4);
    tick(1'b0, 1'b1, 4'b0000, 64'h0);
    check("d1_idle", 32'(dut_disp[1]), 32'hD00D);
    check("d1_inactive", 32'(dut_act[1]), 32'h0);

    // Reset together with frame_done while showing
    tick(1'b0, 1'b1, 4'b1000, 64'h7777_0000_0000_0000);
    tick(1'b1, 1'b1, 4'b1000, 64'h7777_0000_0000_0000);
    check("rstfd_disp", 32'(dut_disp[0]), 32'h0000);
    check("rstfd_ack", 32'(dut_ack[0]), 32'h0);
    check("rstfd_active", 32'(dut_act[0]), 32'h0);

    // Randomized traffic, including back-to-back frames and stray resets
    v_r = 4'h0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) v_r = 4'($urandom_range(0, 15));
      tick(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), v_r,
           {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
